sar_dll_ctrl: RTL



---
 rtl/sar_dll_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sar_dll_ctrl.sv
// Successive-approximation delay-code controller for the FMDLL delay line:
// binary search on COMP, optional saturating +/-1 tracking with loss-of-lock re-search.
module sar_dll_ctrl #(
    parameter int WIDTH  = 10,
    parameter int SETTLE = 0,
    parameter int RELOCK = 8
) (
    input  logic             clk4,
    input  logic             rst,
    input  logic             start,
    input  logic             track_en,
    input  logic             COMP,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_next,
    output logic             busy,
    output logic             done,
    output logic             locked
);

    localparam int IDX_W = $clog2(WIDTH);
    // A zero-width settle counter is illegal, so SETTLE = 0 keeps one bit that is never nonzero.
    localparam int SC_W  = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int RUN_W = $clog2(RELOCK + 1);

    localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] Q_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] Q_MIN    = {WIDTH{1'b0}};
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 1);
    localparam logic [SC_W-1:0]  SC_LOAD  = SC_W'(SETTLE);
    localparam logic [RUN_W-1:0] RUN_LIM  = RUN_W'(RELOCK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        TRACK  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n;
    logic [IDX_W-1:0] idx, idx_n, idx_dec;
    logic [SC_W-1:0]  sc, sc_n;
    logic [RUN_W-1:0] run, run_n, run_inc;
    logic             dir, dir_n;
    logic             done_n, locked_n;
    logic             decide;

    assign decide  = (sc == '0);
    assign idx_dec = idx - IDX_W'(1);
    assign run_inc = ((run == '0) || (COMP != dir)) ? RUN_W'(1) : run + RUN_W'(1);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state;
        q_n      = Q;
        idx_n    = idx;
        sc_n     = sc;
        run_n    = run;
        dir_n    = dir;
        done_n   = 1'b0;
        locked_n = locked;

        case (state)
            SEARCH: begin
                if (!decide) begin
                    sc_n = sc - SC_W'(1);
                end else begin
                    sc_n = SC_LOAD;
                    if (!COMP) begin
                        q_n[idx] = 1'b0;
                    end
                    if (idx != '0) begin
                        q_n[idx_dec] = 1'b1;
                        idx_n        = idx_dec;
                    end else begin
                        done_n   = 1'b1;
                        locked_n = 1'b1;
                        if (track_en) begin
                            state_n = TRACK;
                            run_n   = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end

            TRACK: begin
                if (!track_en) begin
                    state_n = IDLE;
                end else if (!decide) begin
                    sc_n = sc - SC_W'(1);
                end else begin
                    sc_n  = SC_LOAD;
                    dir_n = COMP;
                    if (run_inc == RUN_LIM) begin
                        // Too many same-direction steps: the loop has slipped, search again.
                        locked_n = 1'b0;
                        state_n  = SEARCH;
                        q_n      = MIDSCALE;
                        idx_n    = IDX_TOP;
                        run_n    = '0;
                    end else begin
                        run_n = run_inc;
                        if (COMP) begin
                            q_n = (Q == Q_MAX) ? Q : Q + WIDTH'(1);
                        end else begin
                            q_n = (Q == Q_MIN) ? Q : Q - WIDTH'(1);
                        end
                    end
                end
            end

            default: ;
        endcase

        // start overrides whatever the current state decided, including a final decision.
        if (start) begin
            state_n  = SEARCH;
            q_n      = MIDSCALE;
            idx_n    = IDX_TOP;
            sc_n     = SC_LOAD;
            run_n    = '0;
            done_n   = 1'b0;
            locked_n = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk4) begin
        if (rst) begin
            state  <= IDLE;
            Q      <= MIDSCALE;
            idx    <= IDX_TOP;
            sc     <= SC_LOAD;
            run    <= '0;
            dir    <= 1'b0;
            done   <= 1'b0;
            locked <= 1'b0;
        end else begin
            state  <= state_n;
            Q      <= q_n;
            idx    <= idx_n;
            sc     <= sc_n;
            run    <= run_n;
            dir    <= dir_n;
            done   <= done_n;
            locked <= locked_n;
        end
    end

    assign Q_next = q_n;
    assign busy   = (state == SEARCH);

endmodule
